// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter state encodings and the header word layout,
// used by both the transmit arbiter and the receive-side demux.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_HDR_REQ  = 2'd1,
        ST_HDR_WAIT = 2'd2,
        ST_FWD      = 2'd3
    } arb_state_t;

    // The header word carries the source index starting at this bit; all other bits are zero.
    localparam int HDR_ID_LSB = 0;

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker: returns the first pending source found
// searching upward from last_grant+1, wrapping modulo NUM_SRC.
module rr_select #(
    parameter int NUM_SRC = 2,
    parameter int IDW     = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] pending,
    input  logic [IDW-1:0]     last_grant,
    output logic               valid,
    output logic [IDW-1:0]     index
);

    localparam logic [IDW:0] N_EXT = (IDW+1)'(NUM_SRC);

    logic [IDW-1:0]     cand [NUM_SRC];
    logic [NUM_SRC-1:0] hit;

    // cand[k] is the source k+1 positions after last_grant
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_cand
            logic [IDW:0] sum;
            assign sum      = {1'b0, last_grant} + (IDW+1)'(gi + 1);
            assign cand[gi] = (sum >= N_EXT) ? IDW'(sum - N_EXT) : sum[IDW-1:0];
            assign hit[gi]  = pending[cand[gi]];
        end
    endgenerate

    always_comb begin
        valid = 1'b0;
        index = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (hit[k]) begin
                valid = 1'b1;
                index = cand[k];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among several sources:
// each grant sends a header word (source index) then a fixed-length payload.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int WORD_SIZE        = 8,
    parameter int NUM_SRC          = 2,
    parameter int WORDS_PER_PACKET = 4
) (
    input  logic                          clk,
    input  logic                          n_reset,
    input  logic [NUM_SRC-1:0]            src_pending,
    input  logic [NUM_SRC*WORD_SIZE-1:0]  src_data,
    input  logic [NUM_SRC-1:0]            src_req,
    output logic [NUM_SRC-1:0]            src_ready,
    input  logic                          uart_ready,
    output logic [WORD_SIZE-1:0]          uart_data,
    output logic                          uart_req,
    output logic [$clog2(NUM_SRC)-1:0]    grant_id,
    output logic                          busy
);

    localparam int IDW = $clog2(NUM_SRC);
    localparam int CW  = $clog2(WORDS_PER_PACKET + 1);
    localparam logic [CW-1:0]  LAST_CNT  = CW'(WORDS_PER_PACKET - 1);
    localparam logic [IDW-1:0] LAST_SRC  = IDW'(NUM_SRC - 1);

    arb_state_t     state_reg, state_next;
    logic [CW-1:0]  cnt_reg, cnt_next;
    logic [IDW-1:0] grant_reg, grant_next;
    logic [IDW-1:0] last_grant_reg, last_grant_next;

    logic           sel_valid;
    logic [IDW-1:0] sel_index;
    logic           fwd_strobe;

    logic [WORD_SIZE-1:0] src_word [NUM_SRC];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_word
            assign src_word[gi] = src_data[gi*WORD_SIZE +: WORD_SIZE];
        end
    endgenerate

    rr_select #(
        .NUM_SRC (NUM_SRC),
        .IDW     (IDW)
    ) u_rr_select (
        .pending    (src_pending),
        .last_grant (last_grant_reg),
        .valid      (sel_valid),
        .index      (sel_index)
    );

    assign fwd_strobe = (state_reg == ST_FWD) && src_req[grant_reg];

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            grant_reg      <= '0;
            last_grant_reg <= LAST_SRC;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            grant_reg      <= grant_next;
            last_grant_reg <= last_grant_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        grant_next      = grant_reg;
        last_grant_next = last_grant_reg;
        case (state_reg)
            ST_IDLE: begin
                if (sel_valid) begin
                    grant_next = sel_index;
                    state_next = ST_HDR_REQ;
                end
            end
            ST_HDR_REQ: begin
                if (uart_ready) state_next = ST_HDR_WAIT;
            end
            ST_HDR_WAIT: begin
                if (uart_ready) begin
                    state_next = ST_FWD;
                    cnt_next   = '0;
                end
            end
            ST_FWD: begin
                // The final strobe leaves FWD, so a request on the following cycle is never seen
                if (fwd_strobe) begin
                    cnt_next = cnt_reg + CW'(1);
                    if (cnt_reg == LAST_CNT) begin
                        state_next      = ST_IDLE;
                        last_grant_next = grant_reg;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        uart_req  = 1'b0;
        uart_data = '0;
        src_ready = '0;
        busy      = (state_reg != ST_IDLE);
        case (state_reg)
            ST_HDR_REQ: begin
                uart_req  = uart_ready;
                uart_data = WORD_SIZE'(grant_reg) << HDR_ID_LSB;
            end
            ST_FWD: begin
                src_ready[grant_reg] = uart_ready;
                uart_req             = src_req[grant_reg];
                uart_data            = src_word[grant_reg];
            end
            default: ;
        endcase
    end

    assign grant_id = grant_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: scoreboard of expected UART words plus a table of
// per-cycle vectors applied while a packet is being forwarded.
module tb_uart_tx_arbiter;

    localparam int WS  = 8;
    localparam int NS  = 2;
    localparam int WPP = 4;

    logic            clk = 1'b0;
    logic            n_reset;
    logic [NS-1:0]   src_pending;
    logic [NS*WS-1:0] src_data;
    logic [NS-1:0]   src_req;
    logic [NS-1:0]   src_ready;
    logic            uart_ready;
    logic [WS-1:0]   uart_data;
    logic            uart_req;
    logic            grant_id;
    logic            busy;

    int checks = 0;
    int errors = 0;
    int ready_viol = 0;
    logic [WS-1:0] exp_q [$];

    typedef struct {
        logic          ready;
        logic [1:0]    req;
        logic [WS-1:0] d0;
        logic [WS-1:0] d1;
        logic          exp_req;
        logic [1:0]    exp_ready;
    } vec_t;

    vec_t vecs [6];

    uart_tx_arbiter #(
        .WORD_SIZE        (WS),
        .NUM_SRC          (NS),
        .WORDS_PER_PACKET (WPP)
    ) dut (
        .clk         (clk),
        .n_reset     (n_reset),
        .src_pending (src_pending),
        .src_data    (src_data),
        .src_req     (src_req),
        .src_ready   (src_ready),
        .uart_ready  (uart_ready),
        .uart_data   (uart_data),
        .uart_req    (uart_req),
        .grant_id    (grant_id),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        n_reset     = 1'b0;
        src_req     = '0;
        src_pending = '0;
        uart_ready  = 1'b1;
        repeat (2) tick();
        n_reset = 1'b1;
    endtask

    task automatic wait_busy();
        int t = 0;
        while (!busy && t < 50) begin
            tick();
            t++;
        end
        if (!busy) begin
            checks++;
            errors++;
            $display("FAIL wait_busy: got busy=0 after %0d cycles, required busy=1", t);
        end
    endtask

    // Waits for the source's ready, then sends n words, pushing each onto the scoreboard
    task automatic fwd_words(input int src, input int n);
        int t = 0;
        logic [WS-1:0] w;
        uart_ready = 1'b1;
        while (!src_ready[src] && t < 50) begin
            tick();
            t++;
        end
        if (!src_ready[src]) begin
            checks++;
            errors++;
            $display("FAIL wait_src_ready%0d: got 0 after %0d cycles, required 1", src, t);
        end
        for (int i = 0; i < n; i++) begin
            w = WS'($urandom_range(0, 255));
            src_data[src*WS +: WS] = w;
            src_req = '0;
            src_req[src] = 1'b1;
            exp_q.push_back(w);
            tick();
        end
        src_req = '0;
    endtask

    initial begin
        n_reset     = 1'b0;
        src_pending = '0;
        src_data    = '0;
        src_req     = '0;
        uart_ready  = 1'b1;

        vecs[0] = '{1'b1, 2'b00, 8'h11, 8'h22, 1'b0, 2'b01};
        vecs[1] = '{1'b0, 2'b00, 8'h33, 8'h44, 1'b0, 2'b00};
        vecs[2] = '{1'b1, 2'b10, 8'h55, 8'h66, 1'b0, 2'b01};
        vecs[3] = '{1'b1, 2'b01, 8'hA5, 8'h77, 1'b1, 2'b01};
        vecs[4] = '{1'b0, 2'b11, 8'h3C, 8'h88, 1'b1, 2'b00};
        vecs[5] = '{1'b1, 2'b10, 8'h99, 8'hF0, 1'b0, 2'b01};

        fork
            forever begin
                @(negedge clk);
                if (uart_req) begin
                    $display("uart strobe data=%02h grant=%0d t=%0t", uart_data, grant_id, $time);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_strobe: got data %02h, required no strobe", uart_data);
                    end else begin
                        chk("strobe_data", 32'(uart_data), 32'(exp_q.pop_front()));
                    end
                end
                if ((src_ready & ~(2'b01 << grant_id)) != 2'b00 || (!busy && src_ready != 2'b00))
                    ready_viol++;
            end
        join_none

        // Reset state
        repeat (3) tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_uart_req", 32'(uart_req), 0);
        chk("rst_uart_data", 32'(uart_data), 0);
        chk("rst_src_ready", 32'(src_ready), 0);
        chk("rst_grant_id", 32'(grant_id), 0);
        n_reset = 1'b1;

        // Single source, UART always ready
        exp_q.push_back(8'h00);
        src_pending = 2'b01;
        wait_busy();
        chk("s1_grant", 32'(grant_id), 0);
        src_pending = 2'b00;
        fwd_words(0, WPP);
        chk("s1_busy_after", 32'(busy), 0);
        repeat (3) tick();
        chk("s1_idle_hold", 32'(busy), 0);
        chk("s1_idle_grant", 32'(grant_id), 0);

        // Both pending: rotation 0,1,0,1
        do_reset();
        src_pending = 2'b11;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(WS'(k % 2));
            wait_busy();
            chk($sformatf("s2_grant%0d", k), 32'(grant_id), 32'(k % 2));
            if (k == 3) src_pending = 2'b00;
            fwd_words(k % 2, WPP);
        end
        chk("s2_busy_after", 32'(busy), 0);

        // UART not ready while the header is waiting
        do_reset();
        uart_ready = 1'b0;
        exp_q.push_back(8'h00);
        src_pending = 2'b01;
        wait_busy();
        begin
            int n = 0;
            repeat (10) begin
                tick();
                if (uart_req) n++;
            end
            chk("s3_no_strobe_not_ready", 32'(n), 0);
        end
        chk("s3_busy_held", 32'(busy), 1);
        uart_ready  = 1'b1;
        src_pending = 2'b00;
        #1;
        chk("s3_hdr_strobe", 32'(uart_req), 1);
        fwd_words(0, WPP);
        chk("s3_busy_after", 32'(busy), 0);

        // Vector table in FWD with source 0 granted; source 1 requests are ignored
        do_reset();
        exp_q.push_back(8'h00);
        src_pending = 2'b01;
        wait_busy();
        src_pending = 2'b00;
        begin
            int t = 0;
            while (!src_ready[0] && t < 50) begin
                tick();
                t++;
            end
        end
        for (int i = 0; i < 6; i++) begin
            uart_ready = vecs[i].ready;
            src_req    = vecs[i].req;
            src_data   = {vecs[i].d1, vecs[i].d0};
            if (vecs[i].exp_req) exp_q.push_back(vecs[i].d0);
            #1;
            chk($sformatf("v%0d_uart_req", i), 32'(uart_req), 32'(vecs[i].exp_req));
            chk($sformatf("v%0d_uart_data", i), 32'(uart_data), 32'(vecs[i].d0));
            chk($sformatf("v%0d_src_ready", i), 32'(src_ready), 32'(vecs[i].exp_ready));
            tick();
        end
        src_req = '0;
        fwd_words(0, WPP - 2);
        chk("s4_busy_after", 32'(busy), 0);

        // Reset mid-packet with both pending
        do_reset();
        exp_q.push_back(8'h00);
        src_pending = 2'b11;
        wait_busy();
        fwd_words(0, 2);
        n_reset = 1'b0;
        tick();
        chk("s5_rst_uart_req", 32'(uart_req), 0);
        chk("s5_rst_busy", 32'(busy), 0);
        tick();
        n_reset = 1'b1;
        exp_q.push_back(8'h00);
        wait_busy();
        chk("s5_post_rst_grant", 32'(grant_id), 0);
        src_pending = 2'b00;
        fwd_words(0, WPP);
        chk("s5_busy_after", 32'(busy), 0);

        // Granted source drops pending mid-packet
        do_reset();
        exp_q.push_back(8'h00);
        src_pending = 2'b01;
        wait_busy();
        fwd_words(0, 1);
        src_pending = 2'b00;
        chk("s6_busy_mid", 32'(busy), 1);
        fwd_words(0, WPP - 1);
        chk("s6_busy_after", 32'(busy), 0);
        repeat (3) tick();
        chk("s6_stays_idle", 32'(busy), 0);

        repeat (2) tick();
        chk("sb_empty", 32'(exp_q.size()), 0);
        chk("src_ready_exclusive", 32'(ready_viol), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
